// File: rtl/i2s_adc_deserializer.sv
// i2s_adc_deserializer: oversamples the CODEC ADC serial pins in the CLOCK_50
// domain and deserializes I2S / left-justified frames into parallel signed
// left/right samples, with one sample_valid pulse per stereo frame.
// Optional feature macro: MONO_MIX_EN (adds mono_sample = (L+R)/2).
module i2s_adc_deserializer #(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned I2S_DELAY   = 1,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              bclk_in,
   input  logic              lrck_in,
   input  logic              adcdat_in,
   output logic [DATA_W-1:0] left_sample,
   output logic [DATA_W-1:0] right_sample,
   output logic              sample_valid,
   output logic [DATA_W-1:0] mono_sample,
   output logic              frame_err,
   output logic              err_sticky
);

   localparam int unsigned SLOT_LAST = DATA_W + I2S_DELAY;
   localparam int unsigned CNT_W     = $clog2(SLOT_LAST + 1);
   localparam int unsigned SYNC_N    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   localparam logic [2:0] S_SYNC       = 3'd0;
   localparam logic [2:0] S_LEFT       = 3'd1;
   localparam logic [2:0] S_LEFT_DONE  = 3'd2;
   localparam logic [2:0] S_RIGHT      = 3'd3;
   localparam logic [2:0] S_RIGHT_DONE = 3'd4;

   logic [SYNC_N-1:0] r_bclk_sync, r_lrck_sync, r_dat_sync;
   logic              r_bclk_prev;
   logic              w_bclk, w_lrck, w_dat, w_bclk_rise;

   logic [2:0]        r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic              r_lr_prev, w_lr_prev_nxt;
   logic [DATA_W-1:0] r_shreg, w_shreg_nxt;
   logic [DATA_W-1:0] r_left_hold, w_left_hold_nxt;
   logic [DATA_W-1:0] r_left, w_left_nxt;
   logic [DATA_W-1:0] r_right, w_right_nxt;
   logic              r_valid, w_valid_nxt;
   logic              r_err, w_err_nxt;
   logic              r_sticky;
   logic              w_lr_edge, w_capture, w_done;

   assign w_bclk      = r_bclk_sync[SYNC_N-1];
   assign w_lrck      = r_lrck_sync[SYNC_N-1];
   assign w_dat       = r_dat_sync[SYNC_N-1];
   assign w_bclk_rise = w_bclk & ~r_bclk_prev;

   // Equal-depth synchronizers keep BCLK, LRCK and DATA phase-aligned
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_bclk_sync <= '0;
         r_lrck_sync <= '0;
         r_dat_sync  <= '0;
         r_bclk_prev <= 1'b0;
      end else begin
         r_bclk_sync <= {r_bclk_sync[SYNC_N-2:0], bclk_in};
         r_lrck_sync <= {r_lrck_sync[SYNC_N-2:0], lrck_in};
         r_dat_sync  <= {r_dat_sync[SYNC_N-2:0], adcdat_in};
         r_bclk_prev <= w_bclk;
      end
   end

   // Slot tracking, bit capture and frame FSM; everything advances on bclk_rise
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_lr_prev_nxt   = r_lr_prev;
      w_shreg_nxt     = r_shreg;
      w_left_hold_nxt = r_left_hold;
      w_left_nxt      = r_left;
      w_right_nxt     = r_right;
      w_valid_nxt     = 1'b0;
      w_err_nxt       = 1'b0;
      w_lr_edge       = 1'b0;
      w_capture       = 1'b0;
      w_done          = 1'b0;
      if (w_bclk_rise) begin
         w_lr_prev_nxt = w_lrck;
         w_lr_edge     = w_lrck ^ r_lr_prev;
         if (w_lr_edge)
            w_cnt_nxt = CNT_W'(1);
         else if (r_cnt < CNT_W'(SLOT_LAST))
            w_cnt_nxt = r_cnt + CNT_W'(1);
         // Only edges that advance the count carry data; saturated edges are padding
         w_capture = (w_lr_edge || (r_cnt < CNT_W'(SLOT_LAST))) &&
                     (w_cnt_nxt > CNT_W'(I2S_DELAY));
         if (w_capture)
            w_shreg_nxt = {r_shreg[DATA_W-2:0], w_dat};
         w_done = w_capture && (w_cnt_nxt == CNT_W'(SLOT_LAST));
         case (r_state)
            S_SYNC: begin
               if (w_lr_edge && !w_lrck) w_state_nxt = S_LEFT;
            end
            S_LEFT: begin
               if (w_lr_edge) begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = w_lrck ? S_SYNC : S_LEFT;
               end else if (w_done) begin
                  w_left_hold_nxt = w_shreg_nxt;
                  w_state_nxt     = S_LEFT_DONE;
               end
            end
            S_LEFT_DONE: begin
               if (w_lr_edge) w_state_nxt = w_lrck ? S_RIGHT : S_LEFT;
            end
            S_RIGHT: begin
               if (w_lr_edge) begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = w_lrck ? S_SYNC : S_LEFT;
               end else if (w_done) begin
                  w_left_nxt  = r_left_hold;
                  w_right_nxt = w_shreg_nxt;
                  w_valid_nxt = 1'b1;
                  w_state_nxt = S_RIGHT_DONE;
               end
            end
            S_RIGHT_DONE: begin
               if (w_lr_edge) w_state_nxt = w_lrck ? S_SYNC : S_LEFT;
            end
            default: w_state_nxt = S_SYNC;
         endcase
      end
   end

   // State, datapath and registered outputs
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_state     <= S_SYNC;
         r_cnt       <= '0;
         r_lr_prev   <= 1'b0;
         r_shreg     <= '0;
         r_left_hold <= '0;
         r_left      <= '0;
         r_right     <= '0;
         r_valid     <= 1'b0;
         r_err       <= 1'b0;
         r_sticky    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_lr_prev   <= w_lr_prev_nxt;
         r_shreg     <= w_shreg_nxt;
         r_left_hold <= w_left_hold_nxt;
         r_left      <= w_left_nxt;
         r_right     <= w_right_nxt;
         r_valid     <= w_valid_nxt;
         r_err       <= w_err_nxt;
         r_sticky    <= r_sticky | w_err_nxt;
      end
   end

   assign left_sample  = r_left;
   assign right_sample = r_right;
   assign sample_valid = r_valid;
   assign frame_err    = r_err;
   assign err_sticky   = r_sticky;

`ifdef MONO_MIX_EN
   logic [DATA_W:0]   w_mono_sum;
   logic [DATA_W-1:0] r_mono;

   assign w_mono_sum = {w_left_nxt[DATA_W-1], w_left_nxt} +
                       {w_right_nxt[DATA_W-1], w_right_nxt};

   // Mono average tracks the sample registers in the same cycle
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) r_mono <= '0;
      else       r_mono <= w_mono_sum[DATA_W:1];
   end

   assign mono_sample = r_mono;
`else
   assign mono_sample = '0;
`endif

endmodule

// File: tb/tb_i2s_adc_deserializer.sv
// tb_i2s_adc_deserializer: directed I2S / left-justified frames against the
// deserializer (I2S instance plus a left-justified I2S_DELAY=0 instance).
module tb_i2s_adc_deserializer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        bclk = 1'b0;
   logic        lrck = 1'b0;
   logic        dat = 1'b0;

   logic [15:0] left_s, right_s, mono_s;
   logic        valid_s, err_s, sticky_s;
   logic [15:0] lj_left, lj_right, lj_mono;
   logic        lj_valid, lj_err, lj_sticky;

   int n_checks = 0;
   int n_fail   = 0;
   int vcnt = 0, ecnt = 0, dbl = 0;
   int lj_vcnt = 0, lj_dbl = 0;
   logic prev_valid = 1'b0, lj_prev_valid = 1'b0;
   int v0, e0;

   always #10 clk = ~clk;

   i2s_adc_deserializer #(.DATA_W(16), .I2S_DELAY(1), .SYNC_STAGES(2)) u_dut (
      .CLOCK_50(clk), .reset(reset), .bclk_in(bclk), .lrck_in(lrck), .adcdat_in(dat),
      .left_sample(left_s), .right_sample(right_s), .sample_valid(valid_s),
      .mono_sample(mono_s), .frame_err(err_s), .err_sticky(sticky_s));

   i2s_adc_deserializer #(.DATA_W(16), .I2S_DELAY(0), .SYNC_STAGES(2)) u_dut_lj (
      .CLOCK_50(clk), .reset(reset), .bclk_in(bclk), .lrck_in(lrck), .adcdat_in(dat),
      .left_sample(lj_left), .right_sample(lj_right), .sample_valid(lj_valid),
      .mono_sample(lj_mono), .frame_err(lj_err), .err_sticky(lj_sticky));

   // Pulse counters, sampled away from the active edge
   always @(negedge clk) begin
      if (valid_s) vcnt++;
      if (err_s) ecnt++;
      if (valid_s && prev_valid) dbl++;
      prev_valid = valid_s;
      if (lj_valid) lj_vcnt++;
      if (lj_valid && lj_prev_valid) lj_dbl++;
      lj_prev_valid = lj_valid;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp_v);
      end
   endtask

   // One channel slot of n_edges BCLK periods; data/LRCK change while BCLK is low
   task automatic send_slot(input logic lr, input logic [15:0] word, input int n_edges,
                            input int delay);
      for (int k = 1; k <= n_edges; k++) begin
         int idx;
         idx  = k - 1 - delay;
         bclk = 1'b0;
         lrck = lr;
         dat  = (idx >= 0 && idx < 16) ? word[4'(15 - idx)] : 1'b0;
         #160;
         bclk = 1'b1;
         #160;
      end
   endtask

   task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int delay);
      send_slot(1'b0, l, 32, delay);
      send_slot(1'b1, r, 32, delay);
   endtask

   task automatic pulse_reset();
      #20 reset = 1'b1;
      #60 reset = 1'b0;
      #40;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_left"}, 32'(left_s), 32'h0);
      check_eq({tag, "_right"}, 32'(right_s), 32'h0);
      check_eq({tag, "_valid"}, 32'(valid_s), 32'h0);
      check_eq({tag, "_mono"}, 32'(mono_s), 32'h0);
      check_eq({tag, "_err"}, 32'(err_s), 32'h0);
      check_eq({tag, "_sticky"}, 32'(sticky_s), 32'h0);
   endtask

   function automatic logic [15:0] mono_exp(input logic [15:0] v);
`ifdef MONO_MIX_EN
      return v;
`else
      return (v === 16'hx) ? 16'h1 : 16'h0;
`endif
   endfunction

   initial begin
      #60;
      check_all_zero("reset");
      reset = 1'b0;
      #40;

      // Three back-to-back I2S frames after one ignored right slot
      v0 = vcnt;
      send_slot(1'b1, 16'h0000, 32, 1);
      repeat (3) send_frame(16'h1234, 16'hABCD, 1);
      #200;
      check_eq("t1_valid_cnt", 32'(vcnt - v0), 32'd3);
      check_eq("t1_left", 32'(left_s), 32'h1234);
      check_eq("t1_right", 32'(right_s), 32'hABCD);
      check_eq("t1_sticky", 32'(sticky_s), 32'h0);
      check_eq("t1_mono", 32'(mono_s), 32'(mono_exp(16'hDF00)));

      // Mono extremes
      send_frame(16'h7FFF, 16'h7FFF, 1);
      #200;
      check_eq("t2_left", 32'(left_s), 32'h7FFF);
      check_eq("t2_mono_pos", 32'(mono_s), 32'(mono_exp(16'h7FFF)));
      send_frame(16'h8000, 16'h8000, 1);
      #200;
      check_eq("t2_right", 32'(right_s), 32'h8000);
      check_eq("t2_mono_neg", 32'(mono_s), 32'(mono_exp(16'h8000)));

      // Start mid-right slot: no output until a full left then right word
      pulse_reset();
      send_slot(1'b1, 16'hAAAA, 10, 1);
      v0 = vcnt;
      send_slot(1'b0, 16'h0F0F, 32, 1);
      #200;
      check_eq("t3_no_valid_yet", 32'(vcnt - v0), 32'd0);
      send_slot(1'b1, 16'hF0F0, 32, 1);
      #200;
      check_eq("t3_valid_cnt", 32'(vcnt - v0), 32'd1);
      check_eq("t3_left", 32'(left_s), 32'h0F0F);
      check_eq("t3_right", 32'(right_s), 32'hF0F0);

      // Short left slot (10 BCLK)
      v0 = vcnt; e0 = ecnt;
      send_slot(1'b0, 16'h5555, 10, 1);
      send_slot(1'b1, 16'h3333, 32, 1);
      #200;
      check_eq("t4_err_cnt", 32'(ecnt - e0), 32'd1);
      check_eq("t4_sticky", 32'(sticky_s), 32'h1);
      check_eq("t4_no_valid", 32'(vcnt - v0), 32'd0);
      check_eq("t4_left_hold", 32'(left_s), 32'h0F0F);
      check_eq("t4_right_hold", 32'(right_s), 32'hF0F0);
      send_frame(16'h0001, 16'hFFFF, 1);
      #200;
      check_eq("t4_recover_valid", 32'(vcnt - v0), 32'd1);
      check_eq("t4_recover_left", 32'(left_s), 32'h0001);
      check_eq("t4_recover_right", 32'(right_s), 32'hFFFF);
      check_eq("t4_err_cnt_after", 32'(ecnt - e0), 32'd1);

      // Right slot one edge short (16): error, left slot restarts on that edge
      v0 = vcnt; e0 = ecnt;
      send_slot(1'b0, 16'h1357, 32, 1);
      send_slot(1'b1, 16'h2468, 16, 1);
      send_slot(1'b0, 16'h2222, 32, 1);
      send_slot(1'b1, 16'h4444, 32, 1);
      #200;
      check_eq("t5_err_cnt", 32'(ecnt - e0), 32'd1);
      check_eq("t5_valid_cnt", 32'(vcnt - v0), 32'd1);
      check_eq("t5_left", 32'(left_s), 32'h2222);
      check_eq("t5_right", 32'(right_s), 32'h4444);

      // Minimum-length slots (17 BCLK)
      v0 = vcnt; e0 = ecnt;
      send_slot(1'b0, 16'h1111, 17, 1);
      send_slot(1'b1, 16'h7E81, 17, 1);
      #200;
      check_eq("t6_valid_cnt", 32'(vcnt - v0), 32'd1);
      check_eq("t6_err_cnt", 32'(ecnt - e0), 32'd0);
      check_eq("t6_left", 32'(left_s), 32'h1111);
      check_eq("t6_right", 32'(right_s), 32'h7E81);

      // Asynchronous reset in the middle of a right word
      send_slot(1'b0, 16'hBEEF, 32, 1);
      send_slot(1'b1, 16'hFACE, 8, 1);
      #3 reset = 1'b1;
      #1 check_all_zero("t7_async");
      #56 reset = 1'b0;
      #40;
      v0 = vcnt;
      send_slot(1'b1, 16'h0000, 4, 1);
      send_frame(16'hCAFE, 16'h0BAD, 1);
      #200;
      check_eq("t7_valid_cnt", 32'(vcnt - v0), 32'd1);
      check_eq("t7_left", 32'(left_s), 32'hCAFE);
      check_eq("t7_right", 32'(right_s), 32'h0BAD);
      check_eq("t7_sticky", 32'(sticky_s), 32'h0);

      // Left-justified stream into the I2S_DELAY=0 instance
      pulse_reset();
      v0 = lj_vcnt;
      send_slot(1'b1, 16'h0000, 4, 0);
      send_frame(16'h8001, 16'h7FFE, 0);
      #200;
      check_eq("t8_lj_valid_cnt", 32'(lj_vcnt - v0), 32'd1);
      check_eq("t8_lj_left", 32'(lj_left), 32'h8001);
      check_eq("t8_lj_right", 32'(lj_right), 32'h7FFE);
      check_eq("t8_lj_sticky", 32'(lj_sticky), 32'h0);
      check_eq("t8_lj_mono", 32'(lj_mono), 32'(mono_exp(16'hFFFF)));

      check_eq("no_double_valid", 32'(dbl), 32'd0);
      check_eq("lj_no_double_valid", 32'(lj_dbl), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
